// File: rtl/tdc_hit_arbiter.sv
// rtl/tdc_hit_arbiter.sv - fixed-priority arbiter merging per-channel TDC hits into one output stream
// Each channel has one slot. Hits that land on an occupied slot are counted as drops.

module tdc_hit_arbiter #(
    parameter int    WIDTH        = 8,
    parameter int    DATA_WIDTH   = 16,
    parameter string LSB_PRIORITY = "LOW",
    parameter int    DROP_WIDTH   = 16
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [WIDTH-1:0]              hit_valid,
    input  logic [WIDTH*DATA_WIDTH-1:0]   hit_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(WIDTH)-1:0]      out_channel,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [WIDTH-1:0]              pending,
    output logic [DROP_WIDTH-1:0]         drop_count,
    input  logic                          drop_clear
);

    localparam int CW = $clog2(WIDTH);
    localparam int NW = $clog2(WIDTH + 1);
    localparam int SW = ((DROP_WIDTH > NW) ? DROP_WIDTH : NW) + 1;
    localparam bit MSB_WINS = (LSB_PRIORITY != "HIGH");
    localparam logic [DROP_WIDTH-1:0] DROP_MAX = '1;

    logic [DATA_WIDTH-1:0] payload_q [WIDTH];
    logic                  loadable;
    logic                  grant_valid;
    logic [CW-1:0]         grant_idx;
    logic [WIDTH-1:0]      freed;
    logic [WIDTH-1:0]      capture;
    logic [WIDTH-1:0]      drop;
    logic [WIDTH-1:0]      pending_d;
    logic [NW-1:0]         drop_num;
    logic [SW-1:0]         drop_sum;

    assign loadable    = !out_valid || out_ready;
    assign grant_valid = loadable && (|pending);

    // Later assignments override earlier ones, so loop order sets which end wins.
    always_comb begin
        grant_idx = '0;
        if (MSB_WINS) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (pending[i]) grant_idx = CW'(i);
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (pending[i]) grant_idx = CW'(i);
            end
        end
    end

    always_comb begin
        freed = '0;
        if (grant_valid) freed[grant_idx] = 1'b1;
        capture   = hit_valid & (~pending | freed);
        drop      = hit_valid & pending & ~freed;
        pending_d = (pending & ~freed) | capture;
        drop_num  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            drop_num = drop_num + NW'(drop[i]);
        end
        drop_sum = SW'(drop_count) + SW'(drop_num);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                payload_q[i] <= '0;
            end
        end else begin
            pending <= pending_d;
            for (int i = 0; i < WIDTH; i++) begin
                if (capture[i]) payload_q[i] <= hit_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid   <= 1'b0;
            out_channel <= '0;
            out_data    <= '0;
        end else if (loadable) begin
            if (grant_valid) begin
                out_valid   <= 1'b1;
                out_channel <= grant_idx;
                out_data    <= payload_q[grant_idx];
            end else begin
                out_valid   <= 1'b0;
            end
        end
    end

    // Clear takes precedence and swallows any drops seen on the same edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            drop_count <= '0;
        end else if (drop_clear) begin
            drop_count <= '0;
        end else if (drop_sum > SW'(DROP_MAX)) begin
            drop_count <= DROP_MAX;
        end else begin
            drop_count <= drop_sum[DROP_WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_tdc_hit_arbiter.sv
// tb/tb_tdc_hit_arbiter.sv - scoreboard bench for tdc_hit_arbiter, LOW and HIGH priority instances

module tb_tdc_hit_arbiter;

    typedef struct packed {
        logic [2:0]  ch;
        logic [15:0] data;
    } item_t;

    logic         clock = 1'b0;
    logic         reset_n;
    logic [7:0]   hit_valid;
    logic [127:0] hit_data;
    logic         out_ready;
    logic         drop_clear;

    logic         ov_lo, ov_hi;
    logic [2:0]   och_lo, och_hi;
    logic [15:0]  od_lo, od_hi;
    logic [7:0]   pend_lo, pend_hi;
    logic [15:0]  dc_lo;
    logic [2:0]   dc_hi;

    item_t q_lo[$];
    item_t q_hi[$];
    bit    chk_hi = 1'b0;
    int    passed = 0;
    int    total  = 0;

    always #5 clock = ~clock;

    tdc_hit_arbiter #(.WIDTH(8), .DATA_WIDTH(16), .LSB_PRIORITY("LOW"), .DROP_WIDTH(16)) dut_lo (
        .clock(clock), .reset_n(reset_n), .hit_valid(hit_valid), .hit_data(hit_data),
        .out_valid(ov_lo), .out_ready(out_ready), .out_channel(och_lo), .out_data(od_lo),
        .pending(pend_lo), .drop_count(dc_lo), .drop_clear(drop_clear)
    );

    tdc_hit_arbiter #(.WIDTH(8), .DATA_WIDTH(16), .LSB_PRIORITY("HIGH"), .DROP_WIDTH(3)) dut_hi (
        .clock(clock), .reset_n(reset_n), .hit_valid(hit_valid), .hit_data(hit_data),
        .out_valid(ov_hi), .out_ready(out_ready), .out_channel(och_hi), .out_data(od_hi),
        .pending(pend_hi), .drop_count(dc_hi), .drop_clear(drop_clear)
    );

    // Inputs change 1 time unit after posedge, so the negedge sees the handshake the next edge uses.
    always @(negedge clock) begin
        if (reset_n && ov_lo && out_ready) begin
            item_t e;
            total++;
            if (q_lo.size() == 0) begin
                $display("FAIL sb_lo unexpected: got ch=%0d data=%h required no output", och_lo, od_lo);
            end else begin
                e = q_lo.pop_front();
                if (och_lo !== e.ch || od_lo !== e.data)
                    $display("FAIL sb_lo: got ch=%0d data=%h required ch=%0d data=%h", och_lo, od_lo, e.ch, e.data);
                else passed++;
            end
        end
    end

    always @(negedge clock) begin
        if (reset_n && chk_hi && ov_hi && out_ready) begin
            item_t e;
            total++;
            if (q_hi.size() == 0) begin
                $display("FAIL sb_hi unexpected: got ch=%0d data=%h required no output", och_hi, od_hi);
            end else begin
                e = q_hi.pop_front();
                if (och_hi !== e.ch || od_hi !== e.data)
                    $display("FAIL sb_hi: got ch=%0d data=%h required ch=%0d data=%h", och_hi, od_hi, e.ch, e.data);
                else passed++;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_hit(input int ch, input logic [15:0] d);
        hit_valid[ch] = 1'b1;
        hit_data[ch*16 +: 16] = d;
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        hit_valid  = '0;
        drop_clear = 1'b0;
        out_ready  = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        q_lo.delete();
        q_hi.delete();
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        out_ready  = 1'b1;
        drop_clear = 1'b0;
        hit_valid  = 8'hFF;
        hit_data   = {8{16'hA5A5}};
        repeat (2) @(posedge clock);
        #1;
        total++; if ({ov_lo, och_lo, od_lo, pend_lo, dc_lo} !== '0)
            $display("FAIL reset_outputs: got %h required 0", {ov_lo, och_lo, od_lo, pend_lo, dc_lo}); else passed++;
        reset_n   = 1'b1;
        hit_valid = '0;
        tick();
        tick();
        total++; if (pend_lo !== 8'h00) $display("FAIL reset_hits_lost: got %h required 00", pend_lo); else passed++;
        total++; if (ov_lo !== 1'b0) $display("FAIL reset_no_out: got %b required 0", ov_lo); else passed++;
        total++; if (dc_lo !== 16'd0) $display("FAIL reset_no_drop: got %0d required 0", dc_lo); else passed++;
    endtask

    task automatic test_single_hit();
        do_reset();
        out_ready = 1'b1;
        drive_hit(2, 16'hBEEF);
        q_lo.push_back({3'd2, 16'hBEEF});
        tick();
        hit_valid = '0;
        total++; if (pend_lo !== 8'h04 || ov_lo !== 1'b0)
            $display("FAIL single_edge1: got pend=%h ov=%b required pend=04 ov=0", pend_lo, ov_lo); else passed++;
        tick();
        total++; if (ov_lo !== 1'b1 || och_lo !== 3'd2 || od_lo !== 16'hBEEF)
            $display("FAIL single_edge2: got ov=%b ch=%0d data=%h required 1 2 beef", ov_lo, och_lo, od_lo); else passed++;
        tick();
        total++; if (ov_lo !== 1'b0) $display("FAIL single_edge3: got ov=%b required 0", ov_lo); else passed++;
        total++; if (q_lo.size() != 0) $display("FAIL single_drained: got %0d left required 0", q_lo.size()); else passed++;
    endtask

    task automatic test_simultaneous();
        do_reset();
        out_ready = 1'b1;
        chk_hi    = 1'b1;
        drive_hit(7, 16'h7777);
        drive_hit(0, 16'h0A0A);
        q_lo.push_back({3'd7, 16'h7777});
        q_lo.push_back({3'd0, 16'h0A0A});
        q_hi.push_back({3'd0, 16'h0A0A});
        q_hi.push_back({3'd7, 16'h7777});
        tick();
        hit_valid = '0;
        tick();
        total++; if (och_lo !== 3'd7 || och_hi !== 3'd0)
            $display("FAIL simul_first: got lo=%0d hi=%0d required lo=7 hi=0", och_lo, och_hi); else passed++;
        tick();
        total++; if (och_lo !== 3'd0 || och_hi !== 3'd7 || !ov_lo || !ov_hi)
            $display("FAIL simul_second: got lo=%0d hi=%0d required lo=0 hi=7", och_lo, och_hi); else passed++;
        tick();
        total++; if (ov_lo !== 1'b0 || ov_hi !== 1'b0)
            $display("FAIL simul_idle: got lo=%b hi=%b required 0 0", ov_lo, ov_hi); else passed++;
        total++; if (q_lo.size() + q_hi.size() != 0)
            $display("FAIL simul_drained: got %0d left required 0", q_lo.size() + q_hi.size()); else passed++;
        chk_hi = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        drive_hit(1, 16'h1111);
        drive_hit(3, 16'h3333);
        drive_hit(5, 16'h5555);
        tick();
        hit_valid = '0;
        total++; if (pend_lo !== 8'h2A) $display("FAIL bp_pending_all: got %h required 2a", pend_lo); else passed++;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (ov_lo !== 1'b1 || och_lo !== 3'd5 || od_lo !== 16'h5555 || pend_lo !== 8'h0A)
                $display("FAIL bp_hold: got ov=%b ch=%0d data=%h pend=%h required 1 5 5555 0a", ov_lo, och_lo, od_lo, pend_lo);
            else passed++;
        end
        q_lo.push_back({3'd5, 16'h5555});
        q_lo.push_back({3'd3, 16'h3333});
        q_lo.push_back({3'd1, 16'h1111});
        out_ready = 1'b1;
        tick();
        total++; if (och_lo !== 3'd3) $display("FAIL bp_release_3: got %0d required 3", och_lo); else passed++;
        tick();
        total++; if (och_lo !== 3'd1) $display("FAIL bp_release_1: got %0d required 1", och_lo); else passed++;
        tick();
        total++; if (ov_lo !== 1'b0 || q_lo.size() != 0)
            $display("FAIL bp_drained: got ov=%b left=%0d required 0 0", ov_lo, q_lo.size()); else passed++;
    endtask

    task automatic test_drop();
        do_reset();
        drive_hit(6, 16'h0066);
        drive_hit(3, 16'h0011);
        tick();
        hit_valid = '0;
        drive_hit(3, 16'h0022);
        tick();
        hit_valid = '0;
        total++; if (dc_lo !== 16'd1) $display("FAIL drop_count: got %0d required 1", dc_lo); else passed++;
        total++; if (pend_lo !== 8'h08) $display("FAIL drop_pending: got %h required 08", pend_lo); else passed++;
        q_lo.push_back({3'd6, 16'h0066});
        q_lo.push_back({3'd3, 16'h0011});
        out_ready = 1'b1;
        tick();
        tick();
        total++; if (ov_lo !== 1'b0 || q_lo.size() != 0)
            $display("FAIL drop_drained: got ov=%b left=%0d required 0 0", ov_lo, q_lo.size()); else passed++;
        drop_clear = 1'b1;
        tick();
        drop_clear = 1'b0;
        total++; if (dc_lo !== 16'd0) $display("FAIL drop_clear: got %0d required 0", dc_lo); else passed++;
    endtask

    task automatic test_multi_drop();
        do_reset();
        hit_valid = 8'hFF;
        tick();
        tick();
        total++; if (dc_lo !== 16'd7 || dc_hi !== 3'd7)
            $display("FAIL mdrop_first: got lo=%0d hi=%0d required 7 7", dc_lo, dc_hi); else passed++;
        tick();
        total++; if (dc_lo !== 16'd15 || dc_hi !== 3'd7)
            $display("FAIL mdrop_saturate: got lo=%0d hi=%0d required 15 7", dc_lo, dc_hi); else passed++;
        total++; if (pend_lo !== 8'hFF || pend_hi !== 8'hFF)
            $display("FAIL mdrop_pending: got lo=%h hi=%h required ff ff", pend_lo, pend_hi); else passed++;
        drop_clear = 1'b1;
        tick();
        drop_clear = 1'b0;
        hit_valid  = '0;
        total++; if (dc_lo !== 16'd0 || dc_hi !== 3'd0)
            $display("FAIL mdrop_clear_wins: got lo=%0d hi=%0d required 0 0", dc_lo, dc_hi); else passed++;
    endtask

    task automatic test_rehit();
        do_reset();
        out_ready = 1'b1;
        drive_hit(2, 16'h0055);
        q_lo.push_back({3'd2, 16'h0055});
        q_lo.push_back({3'd2, 16'h0077});
        tick();
        drive_hit(2, 16'h0077);
        tick();
        hit_valid = '0;
        total++; if (od_lo !== 16'h0055 || pend_lo !== 8'h04 || dc_lo !== 16'd0)
            $display("FAIL rehit_grant: got data=%h pend=%h drops=%0d required 0055 04 0", od_lo, pend_lo, dc_lo); else passed++;
        tick();
        total++; if (ov_lo !== 1'b1 || od_lo !== 16'h0077 || pend_lo !== 8'h00)
            $display("FAIL rehit_again: got ov=%b data=%h pend=%h required 1 0077 00", ov_lo, od_lo, pend_lo); else passed++;
        tick();
        total++; if (ov_lo !== 1'b0 || q_lo.size() != 0)
            $display("FAIL rehit_drained: got ov=%b left=%0d required 0 0", ov_lo, q_lo.size()); else passed++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            hit_valid = '0;
            if (i < 6) begin
                int          ch;
                logic [15:0] d;
                ch = $urandom_range(0, 7);
                d  = 16'($urandom);
                drive_hit(ch, d);
                q_lo.push_back({3'(ch), d});
            end
            tick();
            if (i >= 1) begin
                total++; if (ov_lo !== (i <= 6))
                    $display("FAIL b2b_valid_%0d: got %b required %b", i, ov_lo, (i <= 6)); else passed++;
            end
        end
        hit_valid = '0;
        total++; if (dc_lo !== 16'd0 || q_lo.size() != 0)
            $display("FAIL b2b_end: got drops=%0d left=%0d required 0 0", dc_lo, q_lo.size()); else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive_hit(3, 16'h0033);
        tick();
        hit_valid = '0;
        tick();
        hit_valid = 8'hF0;
        tick();
        hit_valid = '0;
        total++; if (ov_lo !== 1'b1 || pend_lo !== 8'hF0)
            $display("FAIL rmid_setup: got ov=%b pend=%h required 1 f0", ov_lo, pend_lo); else passed++;
        #2;
        reset_n = 1'b0;
        #1;
        total++; if ({ov_lo, och_lo, od_lo, pend_lo, dc_lo} !== '0)
            $display("FAIL rmid_async: got %h required 0", {ov_lo, och_lo, od_lo, pend_lo, dc_lo}); else passed++;
        tick();
        #2;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        q_lo.delete();
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (ov_lo !== 1'b0 || pend_lo !== 8'h00)
                $display("FAIL rmid_stale_%0d: got ov=%b pend=%h required 0 00", i, ov_lo, pend_lo); else passed++;
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        hit_valid  = '0;
        hit_data   = '0;
        out_ready  = 1'b0;
        drop_clear = 1'b0;
        test_reset();
        test_single_hit();
        test_simultaneous();
        test_backpressure();
        test_drop();
        test_multi_drop();
        test_rehit();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
